// File: rtl/accum_sequencer_if.sv
// Command handshake and datapath strobe bundle between a command source and the
// accumulator microsequencer.
interface accum_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              zf_in;
  logic              cf_in;
  logic [DATA_W-1:0] data_out;
  logic              load_bus;
  logic              nla;
  logic              nlb;
  logic              ea;
  logic              eu;
  logic              sub;
  logic              bus_sel;
  logic              busy;
  logic              done;
  logic              zf_q;
  logic              cf_q;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, zf_in, cf_in,
    input  cmd_ready, data_out, load_bus, nla, nlb, ea, eu, sub,
           bus_sel, busy, done, zf_q, cf_q, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, zf_in, cf_in,
    output cmd_ready, data_out, load_bus, nla, nlb, ea, eu, sub,
           bus_sel, busy, done, zf_q, cf_q, err
  );
endinterface

// File: rtl/accum_sequencer.sv
// Microsequencer for the 8-bit adder/accumulator datapath: expands one command at a
// time into registered bus-drive, register-load, ALU-enable and output-select strobes.
module accum_sequencer #(
  parameter int DATA_W   = 8,
  parameter int OUT_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  accum_sequencer_if.slave bus
);

  localparam int CNT_W = (OUT_HOLD > 1) ? $clog2(OUT_HOLD) : 1;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDA = 3'b001,
    OP_LDB = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_OUT = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_LATCH,
    S_EXEC,
    S_WB,
    S_OUT,
    S_DONE
  } state_e;

  state_e            r_state;
  op_e               r_op;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_cmd_ready;
  logic              r_load_bus;
  logic              r_nla;
  logic              r_nlb;
  logic              r_ea;
  logic              r_eu;
  logic              r_sub;
  logic              r_bus_sel;
  logic              r_busy;
  logic              r_done;
  logic              r_zf_q;
  logic              r_cf_q;
  logic              r_err;

  wire w_accept = bus.cmd_valid && r_cmd_ready;

  // NOTE: every register here is non-blocking so all strobes change together on the
  // edge and the async reset can drop them mid-cycle without a partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_hold_cnt  <= '0;
      r_data_out  <= '0;
      r_cmd_ready <= 1'b0;
      r_load_bus  <= 1'b0;
      r_nla       <= 1'b1;
      r_nlb       <= 1'b1;
      r_ea        <= 1'b0;
      r_eu        <= 1'b0;
      r_sub       <= 1'b0;
      r_bus_sel   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_zf_q      <= 1'b0;
      r_cf_q      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_op        <= op_e'(bus.cmd_op);
            r_data_out  <= bus.cmd_data;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            case (bus.cmd_op)
              OP_LDA, OP_LDB: begin
                r_state    <= S_DRIVE;
                r_load_bus <= 1'b1;
              end
              OP_ADD, OP_SUB: begin
                r_state <= S_EXEC;
                r_eu    <= 1'b1;
                r_sub   <= (bus.cmd_op == OP_SUB);
              end
              OP_OUT: begin
                r_state    <= S_OUT;
                r_ea       <= 1'b1;
                r_bus_sel  <= 1'b0;
                r_hold_cnt <= CNT_W'(OUT_HOLD - 1);
              end
              OP_NOP: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
              default: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end
            endcase
          end
        end
        // Second load_bus cycle gives the input buffer time to settle before the latch.
        S_DRIVE: begin
          r_state <= S_LATCH;
          if (r_op == OP_LDA) r_nla <= 1'b0;
          else                r_nlb <= 1'b0;
        end
        S_LATCH: begin
          r_state    <= S_DONE;
          r_load_bus <= 1'b0;
          r_nla      <= 1'b1;
          r_nlb      <= 1'b1;
          r_done     <= 1'b1;
        end
        S_EXEC: begin
          r_state <= S_WB;
          r_nla   <= 1'b0;
        end
        // A and the flags update on the same edge that leaves S_WB.
        S_WB: begin
          r_state <= S_DONE;
          r_eu    <= 1'b0;
          r_sub   <= 1'b0;
          r_nla   <= 1'b1;
          r_zf_q  <= bus.zf_in;
          r_cf_q  <= bus.cf_in;
          r_done  <= 1'b1;
        end
        S_OUT: begin
          if (r_hold_cnt == '0) begin
            r_state   <= S_DONE;
            r_ea      <= 1'b0;
            r_bus_sel <= 1'b1;
            r_done    <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.data_out  = r_data_out;
  assign bus.load_bus  = r_load_bus;
  assign bus.nla       = r_nla;
  assign bus.nlb       = r_nlb;
  assign bus.ea        = r_ea;
  assign bus.eu        = r_eu;
  assign bus.sub       = r_sub;
  assign bus.bus_sel   = r_bus_sel;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.zf_q      = r_zf_q;
  assign bus.cf_q      = r_cf_q;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer with a behavioural A/B/ALU datapath hung on the strobes.
module tb_accum_sequencer;

  localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, LDB = 3'b010,
                         ADD = 3'b011, SUB = 3'b100, OUT = 3'b101, ILL = 3'b111;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  accum_sequencer_if #(.DATA_W(8)) bus_if ();

  accum_sequencer #(.DATA_W(8), .OUT_HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: registers A/B, ALU computing A +/- B, one shared bus.
  logic [7:0] a_reg, b_reg, alu_y, bus_v;
  logic       alu_c;
  assign {alu_c, alu_y} = {1'b0, a_reg} + {1'b0, (bus_if.sub ? ~b_reg : b_reg)} + 9'(bus_if.sub);
  assign bus_v = bus_if.load_bus ? bus_if.data_out :
                 bus_if.ea       ? a_reg :
                 bus_if.eu       ? alu_y : 8'h00;
  assign bus_if.zf_in = (alu_y == 8'h00);
  assign bus_if.cf_in = alu_c;

  always @(posedge clk) begin
    if (!bus_if.nla) a_reg <= bus_v;
    if (!bus_if.nlb) b_reg <= bus_v;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("one_driver", 32'(bus_if.load_bus) + 32'(bus_if.ea) + 32'(bus_if.eu) <= 1, 1);
      check("nla_nlb_excl", !(!bus_if.nla && !bus_if.nlb), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_data  = d;
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  // Counts cycles from the first post-accept cycle to the done cycle, then steps to idle.
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 1;
    while (!bus_if.done && n < 20) begin
      tick();
      n++;
    end
    check(tag, n, exp_lat);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = NOP;
    bus_if.cmd_data  = 8'h00;
    #23;
    check("rst_ready",   bus_if.cmd_ready, 0);
    check("rst_strobes", {bus_if.nla, bus_if.nlb, bus_if.ea, bus_if.eu, bus_if.sub,
                          bus_if.load_bus, bus_if.done, bus_if.bus_sel}, 8'b1100_0001);
    check("rst_regs",    {bus_if.data_out, bus_if.zf_q, bus_if.cf_q, bus_if.err, bus_if.busy}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("ready_after_rst", bus_if.cmd_ready, 1);

    // 1: LDA 0x05 cycle by cycle
    issue(LDA, 8'h05);
    check("lda_c1", {bus_if.load_bus, bus_if.nla, bus_if.nlb, bus_if.done, bus_if.busy, bus_if.cmd_ready}, 6'b111010);
    tick();
    check("lda_c2", {bus_if.load_bus, bus_if.nla, bus_if.nlb, bus_if.done}, 4'b1010);
    tick();
    check("lda_c3", {bus_if.load_bus, bus_if.nla, bus_if.nlb, bus_if.done}, 4'b0111);
    check("lda_a", a_reg, 8'h05);
    tick();
    check("lda_idle", {bus_if.done, bus_if.busy, bus_if.cmd_ready}, 3'b001);

    // 2: LDB 0x03, ADD -> 0x08
    issue(LDB, 8'h03);
    wait_done("ldb_lat", 3);
    check("ldb_b", b_reg, 8'h03);
    issue(ADD, 8'h00);
    check("add_c1", {bus_if.eu, bus_if.sub, bus_if.nla, bus_if.nlb, bus_if.done}, 5'b10110);
    tick();
    check("add_c2", {bus_if.eu, bus_if.sub, bus_if.nla, bus_if.nlb, bus_if.done}, 5'b10010);
    tick();
    check("add_c3", {bus_if.eu, bus_if.nla, bus_if.done}, 3'b011);
    check("add_a", a_reg, 8'h08);
    check("add_flags", {bus_if.zf_q, bus_if.cf_q}, 2'b00);
    tick();

    // 3: 0xFF + 0x01 wraps to 0 with zero and carry
    issue(LDA, 8'hFF);
    wait_done("lda2_lat", 3);
    issue(LDB, 8'h01);
    wait_done("ldb2_lat", 3);
    issue(ADD, 8'h00);
    wait_done("add2_lat", 3);
    check("add2_a", a_reg, 8'h00);
    check("add2_flags", {bus_if.zf_q, bus_if.cf_q}, 2'b11);

    // 4: OUT holds regA for 2 cycles, flags untouched
    issue(OUT, 8'h00);
    check("out_c1", {bus_if.ea, bus_if.bus_sel, bus_if.load_bus, bus_if.eu, bus_if.done}, 5'b10000);
    tick();
    check("out_c2", {bus_if.ea, bus_if.bus_sel, bus_if.done}, 3'b100);
    tick();
    check("out_c3", {bus_if.ea, bus_if.bus_sel, bus_if.done}, 3'b011);
    check("out_flags", {bus_if.zf_q, bus_if.cf_q}, 2'b11);
    tick();
    issue(LDB, 8'h01);
    wait_done("ldb3_lat", 3);
    check("ldb_flags_held", {bus_if.zf_q, bus_if.cf_q}, 2'b11);

    // 3b: SUB 0x00 - 0x01 -> 0xFF
    issue(SUB, 8'h00);
    check("sub_c1", {bus_if.eu, bus_if.sub, bus_if.nla}, 3'b111);
    tick();
    check("sub_c2", {bus_if.eu, bus_if.sub, bus_if.nla}, 3'b110);
    tick();
    check("sub_done", bus_if.done, 1);
    check("sub_a", a_reg, 8'hFF);
    check("sub_flags", {bus_if.zf_q, bus_if.cf_q}, 2'b00);
    tick();

    // 5: illegal opcode, NOP, and commands ignored while busy
    issue(ILL, 8'h5A);
    check("ill_c1", {bus_if.done, bus_if.err, bus_if.load_bus, bus_if.ea, bus_if.eu,
                     bus_if.nla, bus_if.nlb}, 7'b1100011);
    tick();
    check("ill_err_sticky", {bus_if.err, bus_if.cmd_ready}, 2'b11);
    issue(NOP, 8'h00);
    wait_done("nop_lat", 1);
    check("nop_err_sticky", bus_if.err, 1);
    issue(LDA, 8'h11);
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = LDB;
    bus_if.cmd_data  = 8'h22;
    tick();
    check("busy_not_ready", {bus_if.cmd_ready, bus_if.busy}, 2'b01);
    tick();
    check("busy_done", bus_if.done, 1);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    tick();
    check("busy_ignored_b", b_reg, 8'h01);
    check("busy_ignored_a", a_reg, 8'h11);
    check("busy_data_out", bus_if.data_out, 8'h11);
    check("busy_idle", {bus_if.busy, bus_if.cmd_ready}, 2'b01);

    // 6: reset during S_WB of ADD aborts without loading A
    issue(LDB, 8'h20);
    wait_done("ldb4_lat", 3);
    issue(ADD, 8'h00);
    tick();
    check("wb_entered", {bus_if.eu, bus_if.nla}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    check("abort_strobes", {bus_if.eu, bus_if.nla, bus_if.sub, bus_if.done, bus_if.busy,
                            bus_if.cmd_ready, bus_if.err}, 7'b0100000);
    tick();
    check("abort_a", a_reg, 8'h11);
    check("abort_no_done", bus_if.done, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("abort_ready", {bus_if.cmd_ready, bus_if.done, bus_if.busy}, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
